// File: rtl/mem_stage_pkg.sv
// Shared constants for the memory stage: bus widths, load-type codes and
// the load-wait state encoding.
package mem_stage_pkg;

    localparam int ES_TO_MS_BUS_WD = 74;
    localparam int MS_TO_WS_BUS_WD = 70;
    localparam int MS_FWD_BUS_WD   = 39;

    localparam logic [2:0] LD_W  = 3'd0;
    localparam logic [2:0] LD_B  = 3'd1;
    localparam logic [2:0] LD_BU = 3'd2;
    localparam logic [2:0] LD_H  = 3'd3;
    localparam logic [2:0] LD_HU = 3'd4;

    typedef enum logic [1:0] {
        MS_IDLE = 2'd0,
        MS_WAIT = 2'd1,
        MS_HOLD = 2'd2
    } ms_state_e;

endpackage

// File: rtl/mem_stage_load_align.sv
// Combinational load extractor: picks the byte/half addressed by the offset
// and sign- or zero-extends it. Unknown load codes behave as a full word.
module mem_stage_load_align
    import mem_stage_pkg::*;
(
    input  logic [2:0]  ld_type,
    input  logic [1:0]  offset,
    input  logic [31:0] word,
    output logic [31:0] result
);

    logic [7:0]  byte_lane [4];
    logic [15:0] half_lane [2];

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_byte
            assign byte_lane[gi] = word[8*gi +: 8];
        end
        for (gi = 0; gi < 2; gi++) begin : g_half
            assign half_lane[gi] = word[16*gi +: 16];
        end
    endgenerate

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    assign sel_byte = byte_lane[offset];
    assign sel_half = half_lane[offset[1]];

    always_comb begin
        result = word;
        case (ld_type)
            LD_B:    result = {{24{sel_byte[7]}}, sel_byte};
            LD_BU:   result = {24'd0, sel_byte};
            LD_H:    result = {{16{sel_half[15]}}, sel_half};
            LD_HU:   result = {16'd0, sel_half};
            default: result = word;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Pipeline memory stage: latches the EXE bus, waits for load data with a
// hold register so returned data survives a WB stall, and feeds WB and ID.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       ws_allowin,
    output logic                       ms_allowin,
    input  logic                       es_to_ms_valid,
    input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
    output logic                       ms_to_ws_valid,
    output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
    input  logic                       data_sram_data_ok,
    input  logic [31:0]                data_sram_rdata,
    output logic [MS_FWD_BUS_WD-1:0]   ms_fwd_bus
);

    logic                       ms_valid_reg;
    logic [ES_TO_MS_BUS_WD-1:0] bus_reg;
    logic [31:0]                hold_data_reg;
    ms_state_e                  state_reg, state_next;

    logic [2:0]  ld_type;
    logic        res_from_mem;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] alu_res;
    logic [31:0] pc;

    assign {ld_type, res_from_mem, gr_we, dest, alu_res, pc} = bus_reg;

    logic ms_ready_go;
    logic capture;
    logic load_capture;
    logic hold_write;

    always_comb begin
        ms_ready_go = 1'b1;
        if (res_from_mem) begin
            case (state_reg)
                MS_WAIT: ms_ready_go = data_sram_data_ok;
                MS_HOLD: ms_ready_go = 1'b1;
                default: ms_ready_go = 1'b0;
            endcase
        end
    end

    assign ms_allowin     = !ms_valid_reg || (ms_ready_go && ws_allowin);
    assign ms_to_ws_valid = ms_valid_reg && ms_ready_go;
    assign capture        = es_to_ms_valid && ms_allowin;
    assign load_capture   = capture && es_to_ms_bus[ES_TO_MS_BUS_WD-4];
    assign hold_write     = (state_reg == MS_WAIT) && data_sram_data_ok && !ws_allowin;

    // Stray data_ok in IDLE or HOLD has no effect on the state.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            MS_IDLE: if (load_capture) state_next = MS_WAIT;
            MS_WAIT: begin
                if (data_sram_data_ok) begin
                    if (ws_allowin) state_next = load_capture ? MS_WAIT : MS_IDLE;
                    else            state_next = MS_HOLD;
                end
            end
            MS_HOLD: if (ws_allowin) state_next = load_capture ? MS_WAIT : MS_IDLE;
            default: state_next = MS_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ms_valid_reg  <= 1'b0;
            bus_reg       <= '0;
            hold_data_reg <= 32'd0;
            state_reg     <= MS_IDLE;
        end else begin
            state_reg <= state_next;
            if (ms_allowin) ms_valid_reg <= es_to_ms_valid;
            if (capture)    bus_reg      <= es_to_ms_bus;
            if (hold_write) hold_data_reg <= data_sram_rdata;
        end
    end

    logic [31:0] load_word;
    logic [31:0] load_result;
    logic [31:0] final_result;

    assign load_word = (state_reg == MS_HOLD) ? hold_data_reg : data_sram_rdata;

    mem_stage_load_align u_load_align (
        .ld_type (ld_type),
        .offset  (alu_res[1:0]),
        .word    (load_word),
        .result  (load_result)
    );

    assign final_result = res_from_mem ? load_result : alu_res;
    assign ms_to_ws_bus = {gr_we, dest, final_result, pc};

    logic fwd_we;
    logic fwd_pending;

    assign fwd_we      = ms_valid_reg && gr_we;
    assign fwd_pending = ms_valid_reg && res_from_mem && (state_reg == MS_WAIT)
                         && !data_sram_data_ok;
    assign ms_fwd_bus  = {fwd_we, fwd_pending, dest, final_result};

endmodule
